// File: rtl/quadrature_pkg.sv
// Shared types and the A/B transition decoder for the quadrature encoder front end.
package quadrature_pkg;

    typedef enum logic {StInit, StRun} state_e;

    typedef logic signed [1:0] step_t;

    typedef struct packed {
        step_t step;
        logic  illegal;
    } decode_t;

    // {A,B} walks the Gray sequence 00,01,11,10 forward; a two-bit jump is illegal.
    function automatic decode_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        decode_t res;
        res.step    = 2'sb00;
        res.illegal = 1'b0;
        case ({prev, cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: res.step = 2'sb01;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: res.step = 2'sb11;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: res.illegal = 1'b1;
            default: res.step = 2'sb00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/quad_sat_accumulator.sv
// Signed accumulator adding a -1/0/+1 step per cycle, saturating at the type limits,
// with a synchronous zero. sum_sat is the saturated next value, usable as a snapshot.
module quad_sat_accumulator
    import quadrature_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             zero,
    input  step_t            add,
    output logic [WIDTH-1:0] sum_sat
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH:0]   ext;

    always_comb begin
        ext = {acc_q[WIDTH-1], acc_q} + {{(WIDTH-1){add[1]}}, add};
        // Disagreeing top two bits mean the true sum left the WIDTH-bit range.
        if (ext[WIDTH] != ext[WIDTH-1]) begin
            sum_sat = ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sum_sat = ext[WIDTH-1:0];
        end
        acc_d = zero ? '0 : sum_sat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: wrapping position count, per-period saturating velocity
// and a sticky illegal-transition flag, from clean clk-synchronous A/B levels.
module quadrature_decoder
    import quadrature_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH    = 16,
    parameter int unsigned VELOCITY_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enc_a,
    input  logic                      enc_b,
    input  logic                      sample_strobe,
    input  logic                      clear,
    output logic [COUNT_WIDTH-1:0]    position,
    output logic [VELOCITY_WIDTH-1:0] velocity,
    output logic                      velocity_valid,
    output logic                      error
);

    state_e                    state_q, state_d;
    logic [1:0]                ab_q, ab_prev;
    logic [COUNT_WIDTH-1:0]    position_q, position_d;
    logic [VELOCITY_WIDTH-1:0] velocity_q, velocity_d;
    logic                      velocity_valid_q;
    logic                      error_q, error_d;
    decode_t                   decoded;
    step_t                     step;
    logic                      illegal;
    logic [VELOCITY_WIDTH-1:0] acc_sum;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase

        decoded = decode_step(ab_prev, ab_q);
        illegal = (state_q == StRun) && decoded.illegal;
        // A clear discards the step of its own cycle everywhere, including the accumulator.
        step    = ((state_q == StRun) && !clear) ? decoded.step : 2'sb00;

        position_d = clear ? '0 : position_q + {{(COUNT_WIDTH-2){step[1]}}, step};
        error_d    = clear ? 1'b0 : (error_q | illegal);
        velocity_d = velocity_q;
        if (sample_strobe) begin
            velocity_d = clear ? '0 : acc_sum;
        end
    end

    quad_sat_accumulator #(
        .WIDTH (VELOCITY_WIDTH)
    ) u_acc (
        .clk     (clk),
        .reset   (reset),
        .zero    (clear | sample_strobe),
        .add     (step),
        .sum_sat (acc_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StInit;
            ab_q             <= 2'b00;
            ab_prev          <= 2'b00;
            position_q       <= '0;
            velocity_q       <= '0;
            velocity_valid_q <= 1'b0;
            error_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            ab_q    <= {enc_a, enc_b};
            // In INIT both stages take the live level so the first RUN compare sees no motion.
            ab_prev          <= (state_q == StInit) ? {enc_a, enc_b} : ab_q;
            position_q       <= position_d;
            velocity_q       <= velocity_d;
            velocity_valid_q <= sample_strobe;
            error_q          <= error_d;
        end
    end

    assign position       = position_q;
    assign velocity       = velocity_q;
    assign velocity_valid = velocity_valid_q;
    assign error          = error_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: a directed vector table, hand-written
// corner sequences, and random motion checked against a sample-history reference model.
module tb_quadrature_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enc_a, enc_b, sample_strobe, clear;
    logic [15:0] position;
    logic [11:0] velocity;
    logic        velocity_valid, error;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int         m_pos, m_acc, m_vel;
    bit         m_vv, m_err;
    int         edge_n;
    logic [1:0] last1, last2;
    int         ph;

    always #5 clk = ~clk;

    quadrature_decoder #(
        .COUNT_WIDTH    (16),
        .VELOCITY_WIDTH (12)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enc_a          (enc_a),
        .enc_b          (enc_b),
        .sample_strobe  (sample_strobe),
        .clear          (clear),
        .position       (position),
        .velocity       (velocity),
        .velocity_valid (velocity_valid),
        .error          (error)
    );

    function automatic int gray_idx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray(input int i);
        case (i & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int sat12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_model();
        check("position", 32'(position), 32'(m_pos[15:0]));
        check("velocity", 32'(velocity), 32'(m_vel[11:0]));
        check("velocity_valid", 32'(velocity_valid), 32'(m_vv));
        check("error", 32'(error), 32'(m_err));
    endtask

    // The step applied at edge k comes from the samples taken at edges k-2 and k-1;
    // edges 1 and 2 after reset never move the count.
    task automatic model_edge(input logic [1:0] ab, input bit st, input bit cl);
        int s;
        bit ill;
        int d;
        s   = 0;
        ill = 0;
        edge_n++;
        if (edge_n >= 3) begin
            d = (gray_idx(last1) - gray_idx(last2) + 4) % 4;
            if (d == 1) s = 1;
            else if (d == 3) s = -1;
            else if (d == 2) ill = 1;
        end
        if (cl) begin
            m_pos = 0;
            m_acc = 0;
            m_err = 0;
            if (st) m_vel = 0;
        end else begin
            m_pos = (m_pos + s) & 16'hFFFF;
            m_err = m_err | ill;
            if (st) begin
                m_vel = sat12(m_acc + s);
                m_acc = 0;
            end else begin
                m_acc = sat12(m_acc + s);
            end
        end
        m_vv  = st;
        last2 = last1;
        last1 = ab;
    endtask

    task automatic tick(input logic [1:0] ab, input bit st, input bit cl, input bit chk);
        enc_a         = ab[1];
        enc_b         = ab[0];
        sample_strobe = st;
        clear         = cl;
        @(posedge clk);
        model_edge(ab, st, cl);
        #1;
        if (chk) check_model();
    endtask

    task automatic move(input int dir, input int hold, input bit chk);
        ph = ph + dir;
        tick(gray(ph), 0, 0, chk);
        for (int i = 1; i < hold; i++) tick(gray(ph), 0, 0, chk);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick(gray(ph), 0, 0, 1);
    endtask

    task automatic do_reset(input logic [1:0] ab);
        reset         = 1'b1;
        enc_a         = ab[1];
        enc_b         = ab[0];
        sample_strobe = 1'b0;
        clear         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_pos  = 0;
        m_acc  = 0;
        m_vel  = 0;
        m_vv   = 0;
        m_err  = 0;
        edge_n = 0;
        last1  = 2'b00;
        last2  = 2'b00;
        ph     = gray_idx(ab);
        check_model();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  ab;
        bit          st;
        bit          cl;
        logic [15:0] pos;
        logic [11:0] vel;
        bit          vv;
        bit          err;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int pos_before;
        int r;

        vecs[0]  = '{2'b00, 0, 0, 16'd0, 12'd0, 0, 0};
        vecs[1]  = '{2'b01, 0, 0, 16'd0, 12'd0, 0, 0};
        vecs[2]  = '{2'b11, 0, 0, 16'd1, 12'd0, 0, 0};
        vecs[3]  = '{2'b11, 0, 0, 16'd2, 12'd0, 0, 0};
        vecs[4]  = '{2'b10, 0, 0, 16'd2, 12'd0, 0, 0};
        vecs[5]  = '{2'b11, 0, 0, 16'd3, 12'd0, 0, 0};
        vecs[6]  = '{2'b11, 0, 0, 16'd2, 12'd0, 0, 0};
        vecs[7]  = '{2'b00, 0, 0, 16'd2, 12'd0, 0, 0};
        vecs[8]  = '{2'b00, 0, 0, 16'd2, 12'd0, 0, 1};
        vecs[9]  = '{2'b00, 0, 1, 16'd0, 12'd0, 0, 0};
        vecs[10] = '{2'b01, 0, 0, 16'd0, 12'd0, 0, 0};
        vecs[11] = '{2'b01, 1, 0, 16'd1, 12'd1, 1, 0};
        vecs[12] = '{2'b01, 0, 0, 16'd1, 12'd1, 0, 0};

        // Directed vector table from reset with A/B = 00
        do_reset(2'b00);
        foreach (vecs[i]) begin
            tick(vecs[i].ab, vecs[i].st, vecs[i].cl, 0);
            check($sformatf("vec%0d.position", i), 32'(position), 32'(vecs[i].pos));
            check($sformatf("vec%0d.error", i), 32'(error), 32'(vecs[i].err));
            check($sformatf("vec%0d.velocity", i), 32'(velocity), 32'(vecs[i].vel));
            check($sformatf("vec%0d.valid", i), 32'(velocity_valid), 32'(vecs[i].vv));
        end

        // Reset release with A/B = 11: no spurious step out of INIT
        do_reset(2'b11);
        for (int i = 0; i < 10; i++) tick(2'b11, 0, 0, 1);
        check("init_no_step.position", 32'(position), 32'd0);
        check("init_no_step.error", 32'(error), 32'd0);

        // Five forward cycles (one change per 4 clocks), then three reverse
        for (int i = 0; i < 20; i++) move(1, 4, 1);
        settle(2);
        check("fwd20", 32'(position), 32'd20);
        for (int i = 0; i < 12; i++) move(-1, 4, 1);
        settle(2);
        check("rev_to_8", 32'(position), 32'd8);

        // Position wrap at both ends
        tick(gray(ph), 0, 1, 1);
        settle(2);
        for (int i = 0; i < 32767; i++) move(1, 1, 0);
        settle(2);
        check("pos_7fff", 32'(position), 32'h7FFF);
        move(1, 1, 1);
        settle(2);
        check("pos_8000", 32'(position), 32'h8000);
        tick(gray(ph), 0, 1, 1);
        settle(2);
        move(-1, 1, 1);
        settle(2);
        check("pos_ffff", 32'(position), 32'hFFFF);

        // Velocity: strobe lands on the cycle the 10th step is evaluated
        tick(gray(ph), 0, 1, 1);
        settle(2);
        for (int i = 0; i < 10; i++) move(1, 1, 1);
        tick(gray(ph), 1, 0, 1);
        check("vel10", 32'(velocity), 32'd10);
        check("vel10.valid", 32'(velocity_valid), 32'd1);
        settle(1);
        check("vel10.valid_drop", 32'(velocity_valid), 32'd0);
        settle(3);
        tick(gray(ph), 1, 0, 1);
        check("vel_idle", 32'(velocity), 32'd0);
        check("vel_idle.valid", 32'(velocity_valid), 32'd1);

        // Illegal two-bit jump, then legal steps, then clear
        settle(2);
        pos_before = int'(position);
        ph = ph + 2;
        tick(gray(ph), 0, 0, 1);
        settle(2);
        check("illegal.error", 32'(error), 32'd1);
        check("illegal.position", 32'(position), 32'(pos_before));
        for (int i = 0; i < 3; i++) move(1, 2, 1);
        settle(2);
        check("illegal.after_steps", 32'(position), 32'((pos_before + 3) & 16'hFFFF));
        check("illegal.sticky", 32'(error), 32'd1);
        tick(gray(ph), 0, 1, 1);
        check("clear.error", 32'(error), 32'd0);
        check("clear.position", 32'(position), 32'd0);

        // Negative saturation of the period accumulator, then clear+strobe together
        settle(2);
        for (int i = 0; i < 2100; i++) move(-1, 1, 0);
        tick(gray(ph), 1, 0, 1);
        check("vel_sat_neg", 32'(velocity), 32'h800);
        settle(2);
        tick(gray(ph), 1, 1, 1);
        check("clr_strobe.velocity", 32'(velocity), 32'd0);
        check("clr_strobe.valid", 32'(velocity_valid), 32'd1);
        check("clr_strobe.position", 32'(position), 32'd0);

        // Random motion against the model
        do_reset(gray($urandom_range(0, 3)));
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            if (r >= 6 && r <= 9) ph = ph + 1;
            else if (r >= 10 && r <= 13) ph = ph - 1;
            else if (r == 14) ph = ph + 2;
            tick(gray(ph), ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0), 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
